bcd_counter_chain: RTL

- Parametrised multi-digit BCD counter. Generalises the single-decade counter to DIGITS cascaded decades.
- Adds up/down counting, synchronous parallel load with BCD validity checking, a terminal-count flag and a one-cycle wrap pulse.
- Used for display/timebase chains. Multiple instances may be cascaded: this block's ovl drives the next instance's en.

---
 rtl/bcd_counter_chain_if.sv | 24 ++
 rtl/bcd_counter_chain.sv | 111 +++++++++++
 2 files changed

// File: rtl/bcd_counter_chain_if.sv
// Handshake/data bundle for bcd_counter_chain.
// Master drives the control and load inputs; slave is the counter.
interface bcd_counter_chain_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   out;
    logic                  tc;
    logic                  ovl;
    logic                  load_err;

    modport master (
        output en, up, load, load_val,
        input  out, tc, ovl, load_err
    );

    modport slave (
        input  en, up, load, load_val,
        output out, tc, ovl, load_err
    );
endinterface

// File: rtl/bcd_counter_chain.sv
// Cascaded multi-decade up/down BCD counter with load checking and wrap pulse.
// Define BCD_COUNTER_CHAIN_SAT_EN to saturate at terminal count instead of wrapping.
module bcd_counter_chain #(
    parameter int          DIGITS     = 4,
    parameter int unsigned LOAD_CHECK = 1
) (
    input  logic               clk,
    input  logic               rst,
    bcd_counter_chain_if.slave bus
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0] out_q, out_d;
    logic         ovl_q, ovl_d;
    logic         load_err_q, load_err_d;

    logic [W-1:0] step_val;
    logic         wrap;
    logic [W-1:0] load_fix;
    logic         load_bad;
    logic         all9;
    logic         all0;
    logic         tc;

    always_comb begin
        all9 = 1'b1;
        all0 = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (out_q[4*i +: 4] != 4'd9) all9 = 1'b0;
            if (out_q[4*i +: 4] != 4'd0) all0 = 1'b0;
        end
        tc = bus.up ? all9 : all0;
    end

    // Ripple the carry/borrow through the decades; a digit above 9
    // behaves like a wrapping digit: it clears and passes the chain on.
    always_comb begin
        step_val = out_q;
        wrap     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (wrap) begin
                if (bus.up) begin
                    if (out_q[4*i +: 4] >= 4'd9) begin
                        step_val[4*i +: 4] = 4'd0;
                    end else begin
                        step_val[4*i +: 4] = out_q[4*i +: 4] + 4'd1;
                        wrap = 1'b0;
                    end
                end else begin
                    if (out_q[4*i +: 4] == 4'd0) begin
                        step_val[4*i +: 4] = 4'd9;
                    end else if (out_q[4*i +: 4] > 4'd9) begin
                        step_val[4*i +: 4] = 4'd0;
                    end else begin
                        step_val[4*i +: 4] = out_q[4*i +: 4] - 4'd1;
                        wrap = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        load_fix = bus.load_val;
        load_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.load_val[4*i +: 4] > 4'd9) begin
                load_bad = 1'b1;
                if (LOAD_CHECK != 0) load_fix[4*i +: 4] = 4'd0;
            end
        end
    end

    always_comb begin
        out_d      = out_q;
        ovl_d      = 1'b0;
        load_err_d = 1'b0;
        if (bus.load) begin
            out_d      = load_fix;
            load_err_d = (LOAD_CHECK != 0) && load_bad;
        end else if (bus.en) begin
`ifdef BCD_COUNTER_CHAIN_SAT_EN
            if (tc) begin
                ovl_d = 1'b1;
            end else begin
                out_d = step_val;
            end
`else
            out_d = step_val;
            ovl_d = wrap;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= '0;
            ovl_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            ovl_q      <= ovl_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.out      = out_q;
    assign bus.tc       = tc;
    assign bus.ovl      = ovl_q;
    assign bus.load_err = load_err_q;
endmodule
